uart_tx_arbiter: RTL

Shares the single UART transmitter on the board between two byte sources: source 0 (echo of bytes from the UART receiver) and source 1 (button-triggered message generator). The block takes bytes from each source over a valid/ready handshake, alternates between the sources when both are waiting, and starts one byte at a time on the transmitter with a start pulse. It sits between the RX/button logic and the TX shifter inside the board top level.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_arbiter_rr.sv | 20 ++
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants and types for the board UART path: FSM state encoding and
// the baud-rate figures used by the TX/RX shifters.
package uart_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_START     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    localparam int CLK_FREQ     = 100_000_000;
    localparam int BAUD         = 9600;
    localparam int CLKS_PER_BIT = 10416;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        START     = ST_START,
        WAIT_BUSY = ST_WAIT_BUSY,
        WAIT_DONE = ST_WAIT_DONE
    } tx_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Two-way round-robin pick: combinational, one-hot result; the last-served
// pointer lives in the caller.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] pick
);

    // Single requester wins outright; on a tie the source not served last wins.
    always_comb begin
        pick = 2'b00;
        case (valid)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between the RX echo (source 0) and the button
// message generator (source 1), one byte per start pulse.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int START_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s0_valid,
    input  logic [7:0] s0_data,
    output logic       s0_ready,
    input  logic       s1_valid,
    input  logic [7:0] s1_data,
    output logic       s1_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic [1:0] grant,
    output logic       timeout_err
);

    localparam int               CNT_W    = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    tx_state_t        state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             last_r, last_nxt_s;
    logic [7:0]       tx_data_r, tx_data_nxt_s;
    logic [1:0]       grant_r, grant_nxt_s;
    logic             tx_start_r, tx_start_nxt_s;
    logic             timeout_r, timeout_nxt_s;
    logic [1:0]       pick_s;
    logic             idle_s;

    rr_arbiter2 u_rr (
        .valid (({s1_valid, s0_valid})),
        .last  (last_r),
        .pick  (pick_s)
    );

    assign idle_s      = (state_r == IDLE);
    assign s0_ready    = pick_s[0] & idle_s & ~reset;
    assign s1_ready    = pick_s[1] & idle_s & ~reset;
    assign tx_data     = tx_data_r;
    assign tx_start    = tx_start_r;
    assign grant       = grant_r;
    assign timeout_err = timeout_r;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        last_nxt_s     = last_r;
        tx_data_nxt_s  = tx_data_r;
        grant_nxt_s    = grant_r;
        tx_start_nxt_s = 1'b0;
        timeout_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_s != 2'b00) begin
                    tx_data_nxt_s  = pick_s[1] ? s1_data : s0_data;
                    grant_nxt_s    = pick_s;
                    last_nxt_s     = pick_s[1];
                    tx_start_nxt_s = 1'b1;
                    state_nxt_s    = START;
                end else begin
                    state_nxt_s    = IDLE;
                end
            end
            START: begin
                cnt_nxt_s   = '0;
                state_nxt_s = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt_s = WAIT_DONE;
                end else if (cnt_r >= CNT_LAST) begin
                    timeout_nxt_s = 1'b1;
                    grant_nxt_s   = 2'b00;
                    state_nxt_s   = IDLE;
                end else if (cnt_r != CNT_MAX) begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    grant_nxt_s = 2'b00;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_DONE;
                end
            end
            default: begin
                grant_nxt_s = 2'b00;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, pointer, counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            last_r     <= 1'b1;
            tx_data_r  <= 8'h00;
            grant_r    <= 2'b00;
            tx_start_r <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            last_r     <= last_nxt_s;
            tx_data_r  <= tx_data_nxt_s;
            grant_r    <= grant_nxt_s;
            tx_start_r <= tx_start_nxt_s;
            timeout_r  <= timeout_nxt_s;
        end
    end

endmodule
